id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  Parametrised ID/EX pipeline register for the single-issue datapath.
//  Carries decoded operands, register addresses and control bits from decode to execute.
//  Adds a valid bit, stall (hold), flush (bubble) and a saturating bubble counter.
//  Optional load-use hazard detection inserts its own bubble and requests an upstream stall.
// PARAMETERS
//  DATA_W   32  operand / immediate / PC+4 width
//  RADDR_W  5   register-file address width
//  ALUOP_W  3   ALU op code width
//  SEL_W    6   function-select (funct) width
//  CNT_W    16  bubble counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous reset, active low
//  stall        in   1        hold all stage contents this cycle
//  flush        in   1        replace incoming instruction with a bubble
//  in_valid     in   1        incoming instruction is real
//  dr1, dr2     in   DATA_W   register-file read data
//  sign, cuatro in   DATA_W   sign-extended immediate, PC+4
//  rs           in   RADDR_W  source reg 1 address (hazard compare only)
//  AW, Inm      in   RADDR_W  rt and rd addresses
//  sel          in   SEL_W    funct field
//  aluop        in   ALUOP_W  ALU op
//  regdst, regwrite, memtoreg, alusrc, er, ew, pcsrc  in 1  control bits
//  out_valid    out  1        registered valid
//  (each data/address/control input)_out  out  same width  registered copy
//  hazard_stall out  1        load-use stall request to PC and IF/ID (0 if macro off)
//  bubble_cnt   out  CNT_W    bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): every registered output, including out_valid and bubble_cnt, is 0.
//    hazard_stall is combinational; it is 0 while out_valid=0.
//  - Latency: 1 cycle, input to output.
//  - Priority at each posedge: reset > flush > stall > hazard bubble > normal load.
//  - flush: out_valid and all seven control outputs and aluop_out are 0.
//    Data and address outputs load their inputs; their values are don't-care but deterministic.
//    bubble_cnt increments.
//  - stall (no flush): all outputs hold; bubble_cnt holds.
//    flush and stall asserted together: the flush wins.
//  - Normal load: every output takes its input. out_valid = in_valid.
//    With in_valid=0, control outputs are forced to 0.
//  - Bubble definition: a cycle in which out_valid is loaded as 0 because of flush or hazard.
//    in_valid=0 alone does not count.
//  - bubble_cnt saturates at all-ones and does not wrap.
//  - Control gating: regwrite, ew and pcsrc outputs are 0 whenever out_valid=0.
//    The execute stage relies on this.
// CONFIGURATION
//  LOAD_USE_HAZARD_EN defined:
//   hazard = out_valid & memtoreg_out & er_out & (AW_out != 0) & in_valid
//            & ((AW_out == rs) | (AW_out == AW)).
//   hazard_stall = hazard & ~stall & ~flush (combinational).
//   When hazard_stall=1, the posedge inserts a bubble with the same content rules as flush,
//   and bubble_cnt increments.
//   Upstream holds the instruction, so it reloads the next cycle once the hazard clears.
//  LOAD_USE_HAZARD_EN undefined: hazard_stall is tied to 0; no comparators are built.
// STRUCTURE
//  - pipe_pkg holds the width localparams and a packed ctrl_t struct
//    {regdst, regwrite, memtoreg, alusrc, er, ew, pcsrc, aluop}, plus a CTRL_NOP constant of all zeros.
//  - Sub-module pipe_reg #(W): one W-bit register with rst_n, en and clr.
//    Instantiate it once for the data bundle and once for ctrl_t+valid.
//    clr applies only to the control instance.
//  - Hazard compare and bubble counter live in the top module.
// TESTING
//  1 Reset: drive rst_n=0 for 2 cycles with nonzero inputs
//    -> all outputs are 0 and bubble_cnt=0; then release and load dr1=32'h1234
//    -> dr1_out=32'h1234 one cycle later.
//  2 Stall: load aluop=3'b010, then stall=1 for 3 cycles while inputs change
//    -> outputs stay at aluop=3'b010 with original data; bubble_cnt=0.
//  3 Flush+stall together, with regwrite=1 and ew=1 at the inputs
//    -> out_valid=0, regwrite_out=0, ew_out=0, bubble_cnt=1.
//  4 Load-use hazard (macro on): EX holds lw with AW_out=5'd8, memtoreg=er=1; ID has rs=8
//    -> hazard_stall=1 for 1 cycle, a bubble is inserted, next cycle loads the ID instruction.
//    Repeat with AW_out=0 -> no hazard.
//  5 Saturation with CNT_W=2: issue 5 flushes -> bubble_cnt=2'b11 and stays there.
//  6 Macro off: repeat scenario 4 -> hazard_stall=0 and the instruction loads immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and the control bundle for the ID/EX pipeline register.
//
// Contents
//   DEF_*_W   default widths used by the interface and the top module
//   ctrl_t    packed control bundle {regdst, regwrite, memtoreg, alusrc, er, ew, pcsrc, aluop}
//   CTRL_NOP  all-zero control bundle; this is what a bubble carries
package pipe_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_ALUOP_W = 3;
  localparam int DEF_SEL_W   = 6;
  localparam int DEF_CNT_W   = 16;

  typedef struct packed {
    logic                   regdst;
    logic                   regwrite;
    logic                   memtoreg;
    logic                   alusrc;
    logic                   er;
    logic                   ew;
    logic                   pcsrc;
    logic [DEF_ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decode-side inputs and execute-side outputs of the ID/EX register.
//
// Parameters: DATA_W, RADDR_W, ALUOP_W, SEL_W, CNT_W (defaults from pipe_pkg).
// Modports
//   master  drives stall/flush/in_valid, operands, addresses, control; reads the *_out copies,
//           hazard_stall and bubble_cnt
//   slave   the pipeline register itself (opposite directions)
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = pipe_pkg::DEF_DATA_W,
  parameter int RADDR_W = pipe_pkg::DEF_RADDR_W,
  parameter int ALUOP_W = pipe_pkg::DEF_ALUOP_W,
  parameter int SEL_W   = pipe_pkg::DEF_SEL_W,
  parameter int CNT_W   = pipe_pkg::DEF_CNT_W
) ();

  // decode side
  logic               stall;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  dr1, dr2, sign, cuatro;
  logic [RADDR_W-1:0] rs, AW, Inm;
  logic [SEL_W-1:0]   sel;
  logic [ALUOP_W-1:0] aluop;
  logic               regdst, regwrite, memtoreg, alusrc, er, ew, pcsrc;

  // execute side
  logic               out_valid;
  logic [DATA_W-1:0]  dr1_out, dr2_out, sign_out, cuatro_out;
  logic [RADDR_W-1:0] AW_out, Inm_out;
  logic [SEL_W-1:0]   sel_out;
  logic [ALUOP_W-1:0] aluop_out;
  logic               regdst_out, regwrite_out, memtoreg_out, alusrc_out, er_out, ew_out, pcsrc_out;
  logic               hazard_stall;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output stall, flush, in_valid, dr1, dr2, sign, cuatro, rs, AW, Inm, sel, aluop,
           regdst, regwrite, memtoreg, alusrc, er, ew, pcsrc,
    input  out_valid, dr1_out, dr2_out, sign_out, cuatro_out, AW_out, Inm_out, sel_out, aluop_out,
           regdst_out, regwrite_out, memtoreg_out, alusrc_out, er_out, ew_out, pcsrc_out,
           hazard_stall, bubble_cnt
  );

  modport slave (
    input  stall, flush, in_valid, dr1, dr2, sign, cuatro, rs, AW, Inm, sel, aluop,
           regdst, regwrite, memtoreg, alusrc, er, ew, pcsrc,
    output out_valid, dr1_out, dr2_out, sign_out, cuatro_out, AW_out, Inm_out, sel_out, aluop_out,
           regdst_out, regwrite_out, memtoreg_out, alusrc_out, er_out, ew_out, pcsrc_out,
           hazard_stall, bubble_cnt
  );

endinterface

// File: rtl/pipe_reg.sv
// pipe_reg: one W-bit pipeline register with synchronous active-low reset.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low (clears to 0)
//   en_i   load d_i this cycle
//   clr_i  load 0 this cycle (wins over en_i)
//   d_i    next value
//   q_o    registered value
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid, stall, flush and a bubble counter.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    id_ex_pipe_reg_if.slave: decode inputs, registered *_out copies, hazard_stall,
//          bubble_cnt (saturating count of inserted bubbles)
//
// Build option
//   LOAD_USE_HAZARD_EN  when defined, a load in EX whose destination matches rs or AW of the
//                       instruction in ID raises hazard_stall and the stage inserts a bubble.
//                       When undefined, hazard_stall is 0 and no comparators exist.
//
// Priority at each edge: reset > flush > stall > hazard bubble > normal load.
// ALUOP_W is fixed by pipe_pkg::ctrl_t; the interface must use the same width.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  id_ex_pipe_reg_if.slave bus
);

  localparam int DBUS_W = 4 * DATA_W + 2 * RADDR_W + SEL_W;
  localparam int CBUS_W = $bits(ctrl_t) + 1;

  logic               load_en;
  logic               bubble;
  logic               hazard_stall;
  logic [DBUS_W-1:0]  data_d, data_q;
  logic [CBUS_W-1:0]  cv_d, cv_q;
  ctrl_t              ctrl_in, ctrl_out;
  logic               valid_out;
  logic [RADDR_W-1:0] aw_out;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  // Flush must override a simultaneous stall, so it re-enables the load.
  assign load_en = bus.flush | ~bus.stall;
  assign bubble  = bus.flush | hazard_stall;

  // ---------------- data bundle ----------------
  assign data_d = {bus.dr1, bus.dr2, bus.sign, bus.cuatro, bus.AW, bus.Inm, bus.sel};

  pipe_reg #(.W(DBUS_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (load_en),
    .clr_i (1'b0),
    .d_i   (data_d),
    .q_o   (data_q)
  );

  assign {bus.dr1_out, bus.dr2_out, bus.sign_out, bus.cuatro_out,
          aw_out, bus.Inm_out, bus.sel_out} = data_q;
  assign bus.AW_out = aw_out;

  // ---------------- control bundle + valid ----------------
  assign ctrl_in = '{regdst:   bus.regdst,
                     regwrite: bus.regwrite,
                     memtoreg: bus.memtoreg,
                     alusrc:   bus.alusrc,
                     er:       bus.er,
                     ew:       bus.ew,
                     pcsrc:    bus.pcsrc,
                     aluop:    bus.aluop};

  // A non-real instruction carries no control, so downstream never sees
  // regwrite/ew/pcsrc without out_valid.
  assign cv_d = bus.in_valid ? {ctrl_in, 1'b1} : {CTRL_NOP, 1'b0};

  pipe_reg #(.W(CBUS_W)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (load_en),
    .clr_i (bubble),
    .d_i   (cv_d),
    .q_o   (cv_q)
  );

  assign ctrl_out  = ctrl_t'(cv_q[CBUS_W-1:1]);
  assign valid_out = cv_q[0];

  assign bus.out_valid    = valid_out;
  assign bus.regdst_out   = ctrl_out.regdst;
  assign bus.regwrite_out = ctrl_out.regwrite;
  assign bus.memtoreg_out = ctrl_out.memtoreg;
  assign bus.alusrc_out   = ctrl_out.alusrc;
  assign bus.er_out       = ctrl_out.er;
  assign bus.ew_out       = ctrl_out.ew;
  assign bus.pcsrc_out    = ctrl_out.pcsrc;
  assign bus.aluop_out    = ctrl_out.aluop;

  // ---------------- load-use hazard ----------------
`ifdef LOAD_USE_HAZARD_EN
  logic hazard;

  // $zero never creates a dependency, hence the AW_out != 0 term.
  assign hazard = valid_out & ctrl_out.memtoreg & ctrl_out.er & (aw_out != '0) & bus.in_valid
                & ((aw_out == bus.rs) | (aw_out == bus.AW));
  assign hazard_stall = hazard & ~bus.stall & ~bus.flush;
`else
  logic unused_rs;

  assign unused_rs    = ^bus.rs;
  assign hazard_stall = 1'b0;
`endif

  assign bus.hazard_stall = hazard_stall;

  // ---------------- saturating bubble counter ----------------
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed scoreboard bench for id_ex_pipe_reg (bubble counter 2 bits wide).
// Each vector is driven on a falling edge; its expected hazard_stall (same cycle) and its
// expected registered outputs (after the next rising edge) go into two queues that two
// monitor processes drain and compare. Expectations follow LOAD_USE_HAZARD_EN.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.CNT_W(2)) bus ();

  id_ex_pipe_reg #(.CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        r, st, fl, iv, mem, er;
    logic [31:0] dr1;
    logic [2:0]  alu;
    logic        rw, ew;
    logic [4:0]  rs, aw;
    logic        hz;
    logic        ov_e, cd;
    logic [31:0] dr1_e;
    logic [2:0]  alu_e;
    logic        rw_e, ew_e;
    logic [1:0]  cnt_e;
  } vec_t;

  typedef struct {
    int          idx;
    logic        ov, cd;
    logic [31:0] dr1;
    logic [2:0]  alu;
    logic        rw, ew;
    logic [1:0]  cnt;
  } exp_t;

  typedef struct {
    int   idx;
    logic hz;
  } haz_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  haz_t haz_q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef LOAD_USE_HAZARD_EN
  localparam logic       HZ    = 1'b1;
  localparam logic [1:0] C_MID = 2'd2;
  localparam logic [1:0] C_HI  = 2'd3;
`else
  localparam logic       HZ    = 1'b0;
  localparam logic [1:0] C_MID = 2'd1;
  localparam logic [1:0] C_HI  = 2'd1;
`endif

  task automatic add(input logic r, st, fl, iv, mem, er, input logic [31:0] dr1,
                     input logic [2:0] alu, input logic rw, ew, input logic [4:0] rs, aw,
                     input logic hz, input logic ov_e, cd, input logic [31:0] dr1_e,
                     input logic [2:0] alu_e, input logic rw_e, ew_e, input logic [1:0] cnt_e);
    vec_t v;
    v.r = r; v.st = st; v.fl = fl; v.iv = iv; v.mem = mem; v.er = er;
    v.dr1 = dr1; v.alu = alu; v.rw = rw; v.ew = ew; v.rs = rs; v.aw = aw;
    v.hz = hz; v.ov_e = ov_e; v.cd = cd; v.dr1_e = dr1_e; v.alu_e = alu_e;
    v.rw_e = rw_e; v.ew_e = ew_e; v.cnt_e = cnt_e;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst_n        = v.r;
    bus.stall    = v.st;
    bus.flush    = v.fl;
    bus.in_valid = v.iv;
    bus.dr1      = v.dr1;
    bus.dr2      = ~v.dr1;
    bus.sign     = v.dr1 ^ 32'h5555_5555;
    bus.cuatro   = v.dr1 + 32'd4;
    bus.rs       = v.rs;
    bus.AW       = v.aw;
    bus.Inm      = v.aw + 5'd1;
    bus.sel      = v.dr1[5:0];
    bus.aluop    = v.alu;
    bus.regdst   = v.rw;
    bus.regwrite = v.rw;
    bus.memtoreg = v.mem;
    bus.alusrc   = v.ew;
    bus.er       = v.er;
    bus.ew       = v.ew;
    bus.pcsrc    = v.rw;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    exp_t e;
    haz_t h;
    //   r st fl iv mm er dr1            alu   rw ew rs    aw     hz  ov cd dr1_e          alu_e rw ew cnt
    // reset with live inputs, then first load
    add(0, 0, 0, 1, 1, 1, 32'hDEAD_BEEF, 3'd7, 1, 1, 5'd8, 5'd8, 0,  0, 1, 32'h0,         3'd0, 0, 0, 2'd0);
    add(0, 0, 0, 1, 1, 1, 32'hDEAD_BEEF, 3'd7, 1, 1, 5'd8, 5'd8, 0,  0, 1, 32'h0,         3'd0, 0, 0, 2'd0);
    add(1, 0, 0, 1, 0, 0, 32'h1234,      3'd1, 1, 0, 5'd0, 5'd0, 0,  1, 1, 32'h1234,      3'd1, 1, 0, 2'd0);
    // stall holds for three cycles while inputs change
    add(1, 0, 0, 1, 0, 0, 32'hA5A5,      3'd2, 0, 1, 5'd0, 5'd0, 0,  1, 1, 32'hA5A5,      3'd2, 0, 1, 2'd0);
    add(1, 1, 0, 1, 1, 1, 32'h1111,      3'd5, 1, 0, 5'd3, 5'd3, 0,  1, 1, 32'hA5A5,      3'd2, 0, 1, 2'd0);
    add(1, 1, 0, 1, 1, 1, 32'h2222,      3'd5, 1, 0, 5'd3, 5'd3, 0,  1, 1, 32'hA5A5,      3'd2, 0, 1, 2'd0);
    add(1, 1, 0, 1, 1, 1, 32'h3333,      3'd5, 1, 0, 5'd3, 5'd3, 0,  1, 1, 32'hA5A5,      3'd2, 0, 1, 2'd0);
    // flush+stall together, then a plain in_valid=0 load (not a bubble)
    add(1, 1, 1, 1, 0, 0, 32'h7777,      3'd6, 1, 1, 5'd0, 5'd0, 0,  0, 0, 32'h0,         3'd0, 0, 0, 2'd1);
    add(1, 0, 0, 0, 0, 0, 32'h0BAD,      3'd3, 1, 1, 5'd0, 5'd0, 0,  0, 1, 32'h0BAD,      3'd0, 0, 0, 2'd1);
    // lw r8 in EX, dependent instruction (rs=8) in ID held upstream for two cycles
    add(1, 0, 0, 1, 1, 1, 32'h4C00,      3'd0, 1, 0, 5'd0, 5'd8, 0,  1, 1, 32'h4C00,      3'd0, 1, 0, 2'd1);
`ifdef LOAD_USE_HAZARD_EN
    add(1, 0, 0, 1, 0, 0, 32'h5D00,      3'd4, 1, 1, 5'd8, 5'd3, HZ, 0, 0, 32'h0,         3'd0, 0, 0, C_MID);
`else
    add(1, 0, 0, 1, 0, 0, 32'h5D00,      3'd4, 1, 1, 5'd8, 5'd3, HZ, 1, 1, 32'h5D00,      3'd4, 1, 1, C_MID);
`endif
    add(1, 0, 0, 1, 0, 0, 32'h5D00,      3'd4, 1, 1, 5'd8, 5'd3, 0,  1, 1, 32'h5D00,      3'd4, 1, 1, C_MID);
    // lw r0: matching rs=0 must not raise a hazard
    add(1, 0, 0, 1, 1, 1, 32'h4C01,      3'd0, 1, 0, 5'd0, 5'd0, 0,  1, 1, 32'h4C01,      3'd0, 1, 0, C_MID);
    add(1, 0, 0, 1, 0, 0, 32'h5D01,      3'd4, 1, 1, 5'd0, 5'd0, 0,  1, 1, 32'h5D01,      3'd4, 1, 1, C_MID);
    // lw r9, dependent via AW; first under stall (no request), then free
    add(1, 0, 0, 1, 1, 1, 32'h4C02,      3'd0, 1, 0, 5'd0, 5'd9, 0,  1, 1, 32'h4C02,      3'd0, 1, 0, C_MID);
    add(1, 1, 0, 1, 0, 0, 32'h5D02,      3'd4, 1, 1, 5'd1, 5'd9, 0,  1, 1, 32'h4C02,      3'd0, 1, 0, C_MID);
`ifdef LOAD_USE_HAZARD_EN
    add(1, 0, 0, 1, 0, 0, 32'h5D02,      3'd4, 1, 1, 5'd1, 5'd9, HZ, 0, 0, 32'h0,         3'd0, 0, 0, C_HI);
`else
    add(1, 0, 0, 1, 0, 0, 32'h5D02,      3'd4, 1, 1, 5'd1, 5'd9, HZ, 1, 1, 32'h5D02,      3'd4, 1, 1, C_HI);
`endif
    add(1, 0, 0, 1, 0, 0, 32'h5D02,      3'd4, 1, 1, 5'd1, 5'd9, 0,  1, 1, 32'h5D02,      3'd4, 1, 1, C_HI);
    // reset, then five flushes saturate the 2-bit counter
    add(0, 0, 0, 1, 0, 0, 32'hFFFF,      3'd7, 1, 1, 5'd0, 5'd0, 0,  0, 1, 32'h0,         3'd0, 0, 0, 2'd0);
    add(1, 0, 1, 1, 0, 0, 32'h00F1,      3'd1, 1, 1, 5'd0, 5'd0, 0,  0, 0, 32'h0,         3'd0, 0, 0, 2'd1);
    add(1, 0, 1, 1, 0, 0, 32'h00F2,      3'd1, 1, 1, 5'd0, 5'd0, 0,  0, 0, 32'h0,         3'd0, 0, 0, 2'd2);
    add(1, 0, 1, 1, 0, 0, 32'h00F3,      3'd1, 1, 1, 5'd0, 5'd0, 0,  0, 0, 32'h0,         3'd0, 0, 0, 2'd3);
    add(1, 0, 1, 1, 0, 0, 32'h00F4,      3'd1, 1, 1, 5'd0, 5'd0, 0,  0, 0, 32'h0,         3'd0, 0, 0, 2'd3);
    add(1, 0, 1, 1, 0, 0, 32'h00F5,      3'd1, 1, 1, 5'd0, 5'd0, 0,  0, 0, 32'h0,         3'd0, 0, 0, 2'd3);
    add(1, 0, 0, 1, 0, 0, 32'hCAFE,      3'd7, 1, 1, 5'd0, 5'd0, 0,  1, 1, 32'hCAFE,      3'd7, 1, 1, 2'd3);
    add(1, 1, 0, 0, 0, 0, 32'hBEEF,      3'd5, 0, 0, 5'd0, 5'd0, 0,  1, 1, 32'hCAFE,      3'd7, 1, 1, 2'd3);

    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      h.idx = i;
      h.hz  = vecs[i].hz;
      haz_q.push_back(h);
      e.idx = i;
      e.ov  = vecs[i].ov_e;
      e.cd  = vecs[i].cd;
      e.dr1 = vecs[i].dr1_e;
      e.alu = vecs[i].alu_e;
      e.rw  = vecs[i].rw_e;
      e.ew  = vecs[i].ew_e;
      e.cnt = vecs[i].cnt_e;
      exp_q.push_back(e);
    end
    repeat (3) @(negedge clk);
    chk("drained", -1, 32'(exp_q.size() + haz_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- monitors ----------------
  initial begin : haz_mon
    haz_t h;
    forever begin
      @(negedge clk);
      #3;
      if (haz_q.size() > 0) begin
        h = haz_q.pop_front();
        chk("hazard_stall", h.idx, 32'(bus.hazard_stall), 32'(h.hz));
      end
    end
  end

  initial begin : exp_mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", e.idx, 32'(bus.out_valid), 32'(e.ov));
        if (e.cd) chk("dr1_out", e.idx, bus.dr1_out, e.dr1);
        chk("aluop_out", e.idx, 32'(bus.aluop_out), 32'(e.alu));
        chk("regwrite_out", e.idx, 32'(bus.regwrite_out), 32'(e.rw));
        chk("ew_out", e.idx, 32'(bus.ew_out), 32'(e.ew));
        chk("pcsrc_out", e.idx, 32'(bus.pcsrc_out), 32'(e.rw));
        chk("bubble_cnt", e.idx, 32'(bus.bubble_cnt), 32'(e.cnt));
        $display("vec %0d: out_valid=%0b dr1_out=%h aluop_out=%0d regwrite_out=%0b ew_out=%0b bubble_cnt=%0d",
                 e.idx, bus.out_valid, bus.dr1_out, bus.aluop_out, bus.regwrite_out, bus.ew_out,
                 bus.bubble_cnt);
      end
    end
  end

endmodule
